// File: rtl/fwd_sel_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage MIPS32 pipeline.
// Tracks in-flight destination registers in a shadow pipeline (EX/MEM/WB),
// registers the EX operand-mux select codes, and raises a one-cycle stall on
// load-use hazards.
module fwd_sel_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_imm,
    input  logic        id_wr_en,
    input  logic [4:0]  id_dst,
    input  logic        id_is_load,
    input  logic        flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    // Operand mux select encodings.
    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelMem = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] SelWb  = 2'b10;  // MEM/WB result
    localparam logic [1:0] SelImm = 2'b11;

    localparam logic [15:0] CntMax = 16'hFFFF;

    // EX shadow slot (mirrors ID/EX). Only this slot needs the load flag: by
    // the time a load reaches MEM/WB its data is forwardable like any result.
    logic       ex_valid_q,  ex_valid_d;
    logic       ex_wr_q,     ex_wr_d;
    logic [4:0] ex_dst_q,    ex_dst_d;
    logic       ex_load_q,   ex_load_d;

    // MEM shadow slot (mirrors EX/MEM).
    logic       mem_valid_q;
    logic       mem_wr_q;
    logic [4:0] mem_dst_q;

    // WB shadow slot (mirrors MEM/WB).
    logic       wb_valid_q;
    logic       wb_wr_q;
    logic [4:0] wb_dst_q;

    logic [1:0]  fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0]  fwd_b_sel_q, fwd_b_sel_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic bubble;

    logic a_ex_hit, a_mem_hit, a_wb_hit;
    logic b_ex_hit, b_mem_hit, b_wb_hit;

    // A slot forwards to a source only if it really writes that register;
    // $0 is hard-wired to zero and never forwards.
    function automatic logic slot_hit(input logic       valid,
                                      input logic       wr,
                                      input logic [4:0] dst,
                                      input logic [4:0] src);
        return valid && wr && (dst == src) && (src != 5'd0);
    endfunction

    // Youngest producer wins. A WB hit reads the register file, which is
    // written in the first half-cycle and read in the second.
    function automatic logic [1:0] pick_sel(input logic ex_hit,
                                            input logic mem_hit,
                                            input logic wb_hit);
        logic [1:0] sel;
        sel = SelRf;
        if (ex_hit) begin
            sel = SelMem;
        end else if (mem_hit) begin
            sel = SelWb;
        end else if (wb_hit) begin
            sel = SelRf;
        end
        return sel;
    endfunction

    // Source matches against every shadow slot.
    always_comb begin
        a_ex_hit  = slot_hit(ex_valid_q,  ex_wr_q,  ex_dst_q,  id_rs);
        a_mem_hit = slot_hit(mem_valid_q, mem_wr_q, mem_dst_q, id_rs);
        a_wb_hit  = slot_hit(wb_valid_q,  wb_wr_q,  wb_dst_q,  id_rs);
        b_ex_hit  = slot_hit(ex_valid_q,  ex_wr_q,  ex_dst_q,  id_rt);
        b_mem_hit = slot_hit(mem_valid_q, mem_wr_q, mem_dst_q, id_rt);
        b_wb_hit  = slot_hit(wb_valid_q,  wb_wr_q,  wb_dst_q,  id_rt);
    end

    // Load-use detection; flush squashes the consumer so no stall is needed.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_valid_q && ex_load_q) begin
            hazard = (ex_dst_q == id_rs) || ((ex_dst_q == id_rt) && !id_use_imm);
        end
        stall  = hazard && !flush;
        bubble = !id_valid || flush || stall;
    end

    // Next EX slot, next select codes and next stall count.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_wr_d     = 1'b0;
        ex_dst_d    = 5'd0;
        ex_load_d   = 1'b0;
        fwd_a_sel_d = SelRf;
        fwd_b_sel_d = SelRf;
        stall_cnt_d = stall_cnt_q;

        if (!bubble) begin
            ex_valid_d  = 1'b1;
            ex_wr_d     = id_wr_en;
            ex_dst_d    = id_dst;
            ex_load_d   = id_is_load;
            fwd_a_sel_d = pick_sel(a_ex_hit, a_mem_hit, a_wb_hit);
            fwd_b_sel_d = id_use_imm ? SelImm : pick_sel(b_ex_hit, b_mem_hit, b_wb_hit);
        end

        if (stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Shadow pipeline shift; WB content falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_dst_q    <= 5'd0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dst_q   <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_wr_q     <= 1'b0;
            wb_dst_q    <= 5'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_wr_q     <= ex_wr_d;
            ex_dst_q    <= ex_dst_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= ex_valid_q;
            mem_wr_q    <= ex_wr_q;
            mem_dst_q   <= ex_dst_q;
            wb_valid_q  <= mem_valid_q;
            wb_wr_q     <= mem_wr_q;
            wb_dst_q    <= mem_dst_q;
        end
    end

    // Registered selects and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_sel_q <= SelRf;
            fwd_b_sel_q <= SelRf;
            stall_cnt_q <= 16'd0;
        end else begin
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed testbench for fwd_sel_ctrl.
module tb_fwd_sel_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_imm;
    logic        id_wr_en;
    logic [4:0]  id_dst;
    logic        id_is_load;
    logic        flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    int checks;
    int failures;
    logic [15:0] exp_cnt;

    fwd_sel_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_imm (id_use_imm),
        .id_wr_en   (id_wr_en),
        .id_dst     (id_dst),
        .id_is_load (id_is_load),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_valid   = 1'b0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_use_imm = 1'b0;
        id_wr_en   = 1'b0;
        id_dst     = 5'd0;
        id_is_load = 1'b0;
        flush      = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic imm,
                         input logic wr, input logic [4:0] dst, input logic ld,
                         input logic fl);
        id_valid   = 1'b1;
        id_rs      = rs;
        id_rt      = rt;
        id_use_imm = imm;
        id_wr_en   = wr;
        id_dst     = dst;
        id_is_load = ld;
        flush      = fl;
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop();
        #2;
        checks++;
        if ({fwd_a_sel, fwd_b_sel, stall, stall_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state: a=%b b=%b stall=%b cnt=%h required all zero",
                     fwd_a_sel, fwd_b_sel, stall, stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        tick();
    endtask

    task automatic test_dist1();
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);   // add $3
        tick();
        issue(5'd3, 5'd4, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);   // sub rs=3
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL dist1_stall: stall=%b required 0", stall);
        end
        tick();
        nop();
        checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL dist1_sel: a=%b b=%b required a=01 b=00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_dist2();
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);   // add $3
        tick();
        nop();
        tick();
        issue(5'd1, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);   // or rt=3
        tick();
        nop();
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin
            failures++;
            $display("FAIL dist2_sel: a=%b b=%b required a=00 b=10", fwd_a_sel, fwd_b_sel);
        end
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);   // add $3
        tick();
        nop();
        tick();
        tick();
        issue(5'd3, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);   // distance 3
        tick();
        nop();
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL dist3_sel: a=%b b=%b required a=00 b=00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_double_hit();
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);   // add $5
        tick();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // lw $5
        tick();
        issue(5'd5, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);   // consumer rs=5
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL double_hit_stall: stall=%b required 1", stall);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (stall !== 1'b0 || fwd_a_sel !== 2'b00 || stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL double_hit_bubble: stall=%b a=%b cnt=%h required 0 00 %h",
                     stall, fwd_a_sel, stall_cnt, exp_cnt);
        end
        tick();
        nop();
        checks++;
        if (fwd_a_sel !== 2'b10) begin
            failures++;
            $display("FAIL double_hit_sel: a=%b required 10", fwd_a_sel);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // lw $6
        tick();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // lw $6 again
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load_stall: stall=%b required 0", stall);
        end
        tick();
        issue(5'd6, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);   // first consumer
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall: stall=%b required 1", stall);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (stall !== 1'b0 || stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL b2b_one_stall: stall=%b cnt=%h required 0 %h",
                     stall, stall_cnt, exp_cnt);
        end
        tick();
        issue(5'd1, 5'd6, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);  // second consumer
        checks++;
        if (stall !== 1'b0 || fwd_a_sel !== 2'b10) begin
            failures++;
            $display("FAIL b2b_second: stall=%b a=%b required 0 10", stall, fwd_a_sel);
        end
        tick();
        nop();
    endtask

    task automatic test_zero_imm();
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);   // add $0
        tick();
        issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);   // reader of $0
        tick();
        nop();
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL zero_reg: a=%b b=%b required 00 00", fwd_a_sel, fwd_b_sel);
        end
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);   // add $7
        tick();
        issue(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);   // addi rs=7, rt=7
        tick();
        nop();
        checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b11) begin
            failures++;
            $display("FAIL imm_sel: a=%b b=%b required 01 11", fwd_a_sel, fwd_b_sel);
        end
        drain();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // lw $9
        tick();
        issue(5'd2, 5'd9, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);   // addi rt=9 is immediate
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL imm_no_stall: stall=%b required 0", stall);
        end
        tick();
        nop();
    endtask

    task automatic test_flush();
        drain();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // lw $4
        tick();
        issue(5'd4, 5'd1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1);  // consumer, flushed
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: stall=%b required 0", stall);
        end
        tick();
        issue(5'd11, 5'd4, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall_cnt !== exp_cnt ||
            stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_bubble: a=%b b=%b cnt=%h stall=%b required 00 00 %h 0",
                     fwd_a_sel, fwd_b_sel, stall_cnt, stall, exp_cnt);
        end
        tick();
        nop();
        // Flushed $11 writer must not forward; lw $4 now sits in MEM.
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin
            failures++;
            $display("FAIL flush_ex_invalid: a=%b b=%b required 00 10", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_async_reset();
        drain();
        issue(5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);   // add $3
        tick();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // lw $3
        tick();
        issue(5'd3, 5'd3, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);   // consumer: hazard
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall !== 1'b0 ||
            stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: a=%b b=%b stall=%b cnt=%h required all zero",
                     fwd_a_sel, fwd_b_sel, stall, stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        nop();
        // Tracker restarted empty: old $3 producers must not forward.
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_sel: a=%b b=%b required 00 00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic load_use_pair();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // lw $4
        tick();
        issue(5'd4, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);   // consumer
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL sat_pair_stall: stall=%b required 1", stall);
        end
        tick();
        tick();
        nop();
    endtask

    task automatic test_saturate();
        drain();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        load_use_pair();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach: cnt=%h required ffff", stall_cnt);
        end
        load_use_pair();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold: cnt=%h required ffff", stall_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;
        rst_n    = 1'b0;
        nop();
        test_reset();
        test_dist1();
        test_dist2();
        test_double_hit();
        test_back_to_back();
        test_zero_imm();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
